// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared types and constants for the BIP1 data-memory dump engine
package bip_pkg;

  // Width of one transmitted byte on the UART side.
  localparam int BIP_NB_BYTE = 8;

  // Dump engine sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } bip_state_t;

endpackage

// File: rtl/bip_word_serializer.sv
// rtl/bip_word_serializer.sv - word register that emits its bytes MSB first over valid/ready
module bip_word_serializer
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_BYTE = BIP_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_accept,
  output logic               o_last,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int NB_IDX = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NB_DATA-1:0] word_q;
  logic [NB_IDX-1:0]  idx_q;
  logic               valid_q;
  logic [NB_BYTE-1:0] byte_sel;

  // The final byte of the word is the one at the highest index.
  assign o_last = (idx_q == NB_IDX'(NBYTES - 1));

  // Load latches a fresh word and presents its top byte; accepts step through the rest.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      word_q  <= i_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (i_accept) begin
      if (o_last) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + NB_IDX'(1);
      end
    end
  end

  // Index 0 maps to the most significant byte of the word.
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == NB_IDX'(i)) begin
        byte_sel = word_q[(NBYTES-1-i)*NB_BYTE +: NB_BYTE];
      end
    end
  end

  // Data is forced to zero whenever nothing is being offered.
  assign o_tx_valid = valid_q;
  assign o_tx_data  = valid_q ? byte_sel : '0;

endmodule

// File: rtl/bip_dump_unit.sv
// rtl/bip_dump_unit.sv - streams data memory 0..DUMP_DEPTH-1 to the UART as bytes, MSB first
module bip_dump_unit
  import bip_pkg::*;
#(
  parameter int NB_ADDR    = 11,
  parameter int NB_DATA    = 16,
  parameter int DUMP_DEPTH = 1024,
  parameter int NB_BYTE    = BIP_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_addr_data_mem,
  output logic               o_RdRam,
  input  logic [NB_DATA-1:0] i_data_memory,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  // Counter never passes this value, so a full 2^NB_ADDR dump cannot wrap.
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DUMP_DEPTH - 1);

  bip_state_t         state_q;
  bip_state_t         state_d;
  logic [NB_ADDR-1:0] cnt_q;
  logic               load;
  logic               accept;
  logic               last_byte;

  // State register; reset aborts any dump in progress immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_READ;
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: begin
        if (accept && last_byte) begin
          state_d = (cnt_q == LAST_ADDR) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Word counter: cleared on every new start and after completion, bumped after each word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_DONE) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && i_start) begin
      cnt_q <= '0;
    end else if (state_q == ST_SEND && accept && last_byte && cnt_q != LAST_ADDR) begin
      cnt_q <= cnt_q + NB_ADDR'(1);
    end
  end

  // Memory returns data one cycle after the read strobe, i.e. during WAIT.
  assign load   = (state_q == ST_WAIT);
  assign accept = o_tx_valid && i_tx_ready;

  bip_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_word     (i_data_memory),
    .i_accept   (accept),
    .o_last     (last_byte),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid)
  );

  assign o_addr_data_mem = cnt_q;
  assign o_RdRam         = (state_q == ST_READ);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_bip_dump_unit.sv
// tb/tb_bip_dump_unit.sv - scoreboard bench for bip_dump_unit with an 8-word full-range memory
module tb_bip_dump_unit;

  localparam int NWORDS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        tx_ready;
  logic [2:0]  addr;
  logic        rdram;
  logic [15:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [15:0] mem [NWORDS];

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_bytes[$];
  logic [2:0] obs_reads[$];
  logic [8:0] stall_obs[$];
  int done_cnt, first_valid, done_cyc, busy_drop, zero_viol;

  bip_dump_unit #(
    .NB_ADDR    (3),
    .NB_DATA    (16),
    .DUMP_DEPTH (NWORDS),
    .NB_BYTE    (8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .o_addr_data_mem (addr),
    .o_RdRam         (rdram),
    .i_data_memory   (rdata),
    .o_tx_data       (tx_data),
    .o_tx_valid      (tx_valid),
    .i_tx_ready      (tx_ready),
    .o_busy          (busy),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdram) rdata <= mem[addr];
  end

  task automatic run_dump(input int extra_start_cyc, input int stall_byte, input int stall_len);
    int stall_left;
    bit stalled_once;
    obs_bytes.delete(); obs_reads.delete(); stall_obs.delete();
    done_cnt = 0; first_valid = -1; done_cyc = -1; busy_drop = -1; zero_viol = 0;
    stall_left = 0; stalled_once = 0;
    for (int i = 0; i < NWORDS; i++) begin
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
    @(negedge clk);
    start = 1'b1;
    tx_ready = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = (n == extra_start_cyc);
      if (tx_valid && first_valid < 0) first_valid = n;
      if (!tx_valid && tx_data != 8'h00) zero_viol++;
      if (rdram) obs_reads.push_back(addr);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (!stalled_once && tx_valid && int'(tx_data) == stall_byte) begin
        stall_left = stall_len;
        stalled_once = 1'b1;
      end
      if (stall_left > 0) begin
        stall_obs.push_back({tx_valid, tx_data});
        stall_left--;
        tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
      end
      if (tx_valid && tx_ready) obs_bytes.push_back(tx_data);
      if (!busy && done_cyc > 0) begin
        busy_drop = n;
        break;
      end
    end
    start = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset;
    int seen_done;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, rdram, addr, busy, done} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state: outputs=%h required 0", {tx_valid, tx_data, rdram, addr, busy, done});
    end
    rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort_valid: valid=%b required 1", tx_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_data, rdram, addr, busy, done} !== 15'h0) begin
      failures++;
      $display("FAIL async_abort: outputs=%h required 0", {tx_valid, tx_data, rdram, addr, busy, done});
    end
    seen_done = 0;
    @(negedge clk);
    if (done) seen_done++;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done: done/busy cycles=%0d required 0", seen_done);
    end
  endtask

  task automatic test_basic;
    logic [7:0] e;
    run_dump(-1, -1, 0);
    for (int i = 0; i < obs_bytes.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_bytes[i] !== e) begin
        failures++;
        $display("FAIL basic_byte%0d: got=%h required=%h", i, obs_bytes[i], e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_count: missing=%0d required 0", exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (first_valid != 3) begin
      failures++;
      $display("FAIL basic_first_valid: cycle=%0d required 3", first_valid);
    end
    checks++;
    if (done_cyc != 33 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done: cycle=%0d count=%0d required 33/1", done_cyc, done_cnt);
    end
    checks++;
    if (busy_drop != 34) begin
      failures++;
      $display("FAIL basic_busy_drop: cycle=%0d required 34", busy_drop);
    end
    checks++;
    if (zero_viol != 0) begin
      failures++;
      $display("FAIL basic_idle_data: nonzero=%0d required 0", zero_viol);
    end
    checks++;
    if (obs_reads.size() != NWORDS) begin
      failures++;
      $display("FAIL full_range_reads: count=%0d required %0d", obs_reads.size(), NWORDS);
    end
    for (int i = 0; i < obs_reads.size(); i++) begin
      checks++;
      if (obs_reads[i] !== 3'(i)) begin
        failures++;
        $display("FAIL full_range_addr%0d: got=%0d required=%0d", i, obs_reads[i], i);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e;
    run_dump(-1, 'hAB, 5);
    checks++;
    if (stall_obs.size() != 5) begin
      failures++;
      $display("FAIL bp_stall_len: cycles=%0d required 5", stall_obs.size());
    end
    for (int i = 0; i < stall_obs.size(); i++) begin
      checks++;
      if (stall_obs[i] !== 9'h1AB) begin
        failures++;
        $display("FAIL bp_hold%0d: valid_data=%h required 1ab", i, stall_obs[i]);
      end
    end
    for (int i = 0; i < obs_bytes.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_bytes[i] !== e) begin
        failures++;
        $display("FAIL bp_byte%0d: got=%h required=%h", i, obs_bytes[i], e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: missing=%0d required 0", exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (done_cyc != 38 || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_done: cycle=%0d count=%0d required 38/1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_start_while_busy;
    logic [7:0] e;
    run_dump(7, -1, 0);
    for (int i = 0; i < obs_bytes.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_bytes[i] !== e) begin
        failures++;
        $display("FAIL busy_start_byte%0d: got=%h required=%h", i, obs_bytes[i], e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start_count: missing=%0d required 0", exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (done_cnt != 1 || obs_reads.size() != NWORDS) begin
      failures++;
      $display("FAIL busy_start_once: done=%0d reads=%0d required 1/%0d", done_cnt, obs_reads.size(), NWORDS);
    end
  endtask

  task automatic test_reset_mid_dump;
    logic [7:0] e;
    bit found;
    found = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (rdram && addr == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reach_word2: reached=%b required 1", found);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (addr !== 3'd0 || busy !== 1'b0 || rdram !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort: addr=%0d busy=%b rd=%b required 0/0/0", addr, busy, rdram);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_dump(-1, -1, 0);
    for (int i = 0; i < obs_bytes.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_bytes[i] !== e) begin
        failures++;
        $display("FAIL restart_byte%0d: got=%h required=%h", i, obs_bytes[i], e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_count: missing=%0d required 0", exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (obs_reads.size() == 0 || obs_reads[0] !== 3'd0 || done_cnt != 1) begin
      failures++;
      $display("FAIL restart_origin: reads=%0d done=%0d required first addr 0 and one done", obs_reads.size(), done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tx_ready = 1'b1;
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h00FF; mem[3] = 16'h8001;
    mem[4] = 16'h5A5A; mem[5] = 16'h0F0F; mem[6] = 16'hFFFF; mem[7] = 16'h7E00;
    test_reset;
    test_basic;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_dump;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
